acs_sched: RTL and testbench

ACS_SCHED -- requirements
Module: acs_sched

---
 rtl/acs_sched.sv | 221 ++++++++++++++++++++++
 tb/tb_acs_sched.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/acs_sched.sv
// acs_sched: add-compare-select scheduler for an 8-state, rate-1/2 Viterbi decoder.
// One symbol's four branch metrics are taken per handshake. A single shared ACS unit
// (outside this block) is then time-multiplexed across the 8 trellis states, one per cycle.
// After a one-cycle normalisation pass, the decision word is offered to the consumer.
//
// Ports
//   clk          rising-edge clock
//   rst_n        synchronous active-low reset
//   init         reinitialise path metrics for a new frame (honoured only in IDLE)
//   sym_valid    branch metrics for one symbol are present on bm_in
//   sym_ready    block accepts a symbol this cycle
//   bm_in        four 2-bit branch metrics; codeword k={c1,c0} uses bm_in[2k+1:2k]
//   acs_p0_*     predecessor-0 operands to the shared ACS unit (valid, bmc, pmc)
//   acs_p1_*     predecessor-1 operands to the shared ACS unit (valid, bmc, pmc)
//   acs_sel      ACS chose predecessor 1 (same-cycle return)
//   acs_valid    ACS result is a valid metric (same-cycle return)
//   acs_cost     ACS surviving metric (same-cycle return)
//   dec          survivor decision bit per state
//   dec_mask     per-state validity of the new metrics
//   best_state   state holding the smallest valid new metric (lowest index on ties)
//   dec_valid    dec, dec_mask and best_state are valid
//   dec_ready    consumer accepts the decision word

module acs_sched #(
  parameter int unsigned NSTATE = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       init,
  input  logic       sym_valid,
  output logic       sym_ready,
  input  logic [7:0] bm_in,
  output logic       acs_p0_valid,
  output logic       acs_p1_valid,
  output logic [1:0] acs_p0_bmc,
  output logic [1:0] acs_p1_bmc,
  output logic [7:0] acs_p0_pmc,
  output logic [7:0] acs_p1_pmc,
  input  logic       acs_sel,
  input  logic       acs_valid,
  input  logic [7:0] acs_cost,
  output logic [7:0] dec,
  output logic [7:0] dec_mask,
  output logic [2:0] best_state,
  output logic       dec_valid,
  input  logic       dec_ready
);

  typedef enum logic [1:0] {StIdle, StRun, StNorm, StOut} state_e;

  state_e            state_q;
  logic [2:0]        st_q;
  logic [7:0]        bm_q;
  logic [7:0]        cur_pm_q [NSTATE];
  logic [NSTATE-1:0] cur_v_q;
  logic [7:0]        nxt_pm_q [NSTATE];
  logic [NSTATE-1:0] nxt_v_q;
  logic [7:0]        dec_q;
  logic [2:0]        best_q;
  logic [7:0]        best_min_q;
  logic              best_found_q;
  logic              dec_valid_q;

  // Trellis wiring for the state currently being processed.
  logic [2:0] p0_idx;
  logic [2:0] p1_idx;
  logic [1:0] k0;
  logic [1:0] k1;
  logic [1:0] bm_k0;
  logic [1:0] bm_k1;

  always_comb begin
    p0_idx = {1'b0, st_q[2:1]};
    p1_idx = {1'b1, st_q[2:1]};
    k0     = {st_q[0] ^ p0_idx[1] ^ p0_idx[0], st_q[0] ^ p0_idx[2] ^ p0_idx[0]};
    k1     = {st_q[0] ^ p1_idx[1] ^ p1_idx[0], st_q[0] ^ p1_idx[2] ^ p1_idx[0]};
  end

  always_comb begin
    bm_k0 = 2'd0;
    unique case (k0)
      2'd0: bm_k0 = bm_q[1:0];
      2'd1: bm_k0 = bm_q[3:2];
      2'd2: bm_k0 = bm_q[5:4];
      2'd3: bm_k0 = bm_q[7:6];
      default: bm_k0 = 2'd0;
    endcase
  end

  always_comb begin
    bm_k1 = 2'd0;
    unique case (k1)
      2'd0: bm_k1 = bm_q[1:0];
      2'd1: bm_k1 = bm_q[3:2];
      2'd2: bm_k1 = bm_q[5:4];
      2'd3: bm_k1 = bm_q[7:6];
      default: bm_k1 = 2'd0;
    endcase
  end

  // Operands to the shared ACS unit; quiet outside RUN.
  always_comb begin
    acs_p0_valid = 1'b0;
    acs_p1_valid = 1'b0;
    acs_p0_bmc   = 2'd0;
    acs_p1_bmc   = 2'd0;
    acs_p0_pmc   = 8'd0;
    acs_p1_pmc   = 8'd0;
    if (state_q == StRun) begin
      acs_p0_valid = cur_v_q[p0_idx];
      acs_p1_valid = cur_v_q[p1_idx];
      acs_p0_bmc   = bm_k0;
      acs_p1_bmc   = bm_k1;
      acs_p0_pmc   = cur_pm_q[p0_idx];
      acs_p1_pmc   = cur_pm_q[p1_idx];
    end
  end

  // Normalise only when every valid metric has bit 7 set and at least one is valid;
  // subtracting 128 then amounts to clearing bit 7.
  logic norm_ok;
  logic do_norm;

  always_comb begin
    norm_ok = 1'b1;
    for (int i = 0; i < NSTATE; i++) begin
      if (nxt_v_q[i] && !nxt_pm_q[i][7]) begin
        norm_ok = 1'b0;
      end
    end
    do_norm = norm_ok && (|nxt_v_q);
  end

  // rst_n is folded in so sym_ready is low for the whole reset cycle.
  assign sym_ready  = rst_n && (state_q == StIdle) && !init;

  assign dec        = dec_q;
  assign dec_mask   = nxt_v_q;
  assign best_state = best_q;
  assign dec_valid  = dec_valid_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      st_q         <= 3'd0;
      bm_q         <= 8'd0;
      cur_v_q      <= NSTATE'(1);
      nxt_v_q      <= '0;
      dec_q        <= 8'd0;
      best_q       <= 3'd0;
      best_min_q   <= 8'd0;
      best_found_q <= 1'b0;
      dec_valid_q  <= 1'b0;
      for (int i = 0; i < NSTATE; i++) begin
        cur_pm_q[i] <= 8'd0;
        nxt_pm_q[i] <= 8'd0;
      end
    end else begin
      unique case (state_q)
        StIdle: begin
          // init takes priority over a waiting symbol.
          if (init) begin
            cur_v_q <= NSTATE'(1);
            for (int i = 0; i < NSTATE; i++) begin
              cur_pm_q[i] <= 8'd0;
            end
          end else if (sym_valid) begin
            bm_q         <= bm_in;
            st_q         <= 3'd0;
            best_q       <= 3'd0;
            best_min_q   <= 8'd0;
            best_found_q <= 1'b0;
            state_q      <= StRun;
          end
        end

        StRun: begin
          nxt_pm_q[st_q] <= acs_cost;
          nxt_v_q[st_q]  <= acs_valid;
          dec_q[st_q]    <= acs_sel & acs_valid;
          // Strict less-than keeps the lower index on ties.
          if (acs_valid && (!best_found_q || (acs_cost < best_min_q))) begin
            best_q       <= st_q;
            best_min_q   <= acs_cost;
            best_found_q <= 1'b1;
          end
          st_q <= st_q + 3'd1;
          if (st_q == 3'd7) begin
            state_q <= StNorm;
          end
        end

        StNorm: begin
          if (do_norm) begin
            for (int i = 0; i < NSTATE; i++) begin
              if (nxt_v_q[i]) begin
                nxt_pm_q[i] <= {1'b0, nxt_pm_q[i][6:0]};
              end
            end
          end
          dec_valid_q <= 1'b1;
          state_q     <= StOut;
        end

        StOut: begin
          if (dec_ready) begin
            cur_v_q     <= nxt_v_q;
            for (int i = 0; i < NSTATE; i++) begin
              cur_pm_q[i] <= nxt_pm_q[i];
            end
            dec_valid_q <= 1'b0;
            state_q     <= StIdle;
          end
        end

        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_acs_sched.sv
// Directed bench for acs_sched. A behavioural ACS unit closes the loop combinationally.
module tb_acs_sched;

  logic       clk;
  logic       rst_n;
  logic       init;
  logic       sym_valid;
  logic       sym_ready;
  logic [7:0] bm_in;
  logic       acs_p0_valid;
  logic       acs_p1_valid;
  logic [1:0] acs_p0_bmc;
  logic [1:0] acs_p1_bmc;
  logic [7:0] acs_p0_pmc;
  logic [7:0] acs_p1_pmc;
  logic       acs_sel;
  logic       acs_valid;
  logic [7:0] acs_cost;
  logic [7:0] dec;
  logic [7:0] dec_mask;
  logic [2:0] best_state;
  logic       dec_valid;
  logic       dec_ready;

  int total;
  int bad;

  acs_sched #(.NSTATE(8)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .init         (init),
    .sym_valid    (sym_valid),
    .sym_ready    (sym_ready),
    .bm_in        (bm_in),
    .acs_p0_valid (acs_p0_valid),
    .acs_p1_valid (acs_p1_valid),
    .acs_p0_bmc   (acs_p0_bmc),
    .acs_p1_bmc   (acs_p1_bmc),
    .acs_p0_pmc   (acs_p0_pmc),
    .acs_p1_pmc   (acs_p1_pmc),
    .acs_sel      (acs_sel),
    .acs_valid    (acs_valid),
    .acs_cost     (acs_cost),
    .dec          (dec),
    .dec_mask     (dec_mask),
    .best_state   (best_state),
    .dec_valid    (dec_valid),
    .dec_ready    (dec_ready)
  );

  // Behavioural ACS: add, compare, select; p0 wins ties.
  logic [7:0] c0;
  logic [7:0] c1;
  assign c0        = acs_p0_pmc + {6'd0, acs_p0_bmc};
  assign c1        = acs_p1_pmc + {6'd0, acs_p1_bmc};
  assign acs_valid = acs_p0_valid | acs_p1_valid;
  assign acs_sel   = acs_p1_valid & (!acs_p0_valid | (c1 < c0));
  assign acs_cost  = acs_sel ? c1 : c0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Offers one symbol, captures RUN-phase operands, waits (bounded) for the decision word
  // and optionally stalls dec_ready for 'stall' cycles while checking it holds.
  task automatic run_symbol(input logic [7:0] bm, input int stall,
                            input logic [7:0] e_dec, input logic [7:0] e_mask,
                            input logic [2:0] e_best,
                            output logic [7:0] pmc0, output logic [7:0] pmc2,
                            output logic p1v0, output logic [7:0] o_dec,
                            output logic [7:0] o_mask, output logic [2:0] o_best);
    int lat;
    lat  = 0;
    pmc0 = 8'd0;
    pmc2 = 8'd0;
    p1v0 = 1'b0;
    @(negedge clk);
    init      = 1'b0;
    bm_in     = bm;
    sym_valid = 1'b1;
    dec_ready = (stall == 0);
    #1;
    check("sym_ready_idle", {31'd0, sym_ready}, 32'd1);
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      sym_valid = 1'b0;
      #1;
      if (c == 1) begin
        pmc0 = acs_p0_pmc;
        p1v0 = acs_p1_valid;
      end
      if (c == 3) pmc2 = acs_p0_pmc;
      if (dec_valid) begin
        lat = c;
        break;
      end
    end
    check("latency", lat, 32'd10);
    o_dec  = dec;
    o_mask = dec_mask;
    o_best = best_state;
    if (stall > 0) begin
      for (int k = 0; k < stall; k++) begin
        @(negedge clk);
        #1;
        check("stall_dec_valid", {31'd0, dec_valid}, 32'd1);
        check("stall_dec", {24'd0, dec}, {24'd0, e_dec});
        check("stall_mask", {24'd0, dec_mask}, {24'd0, e_mask});
        check("stall_best", {29'd0, best_state}, {29'd0, e_best});
        check("stall_sym_ready", {31'd0, sym_ready}, 32'd0);
      end
      dec_ready = 1'b1;
    end
  endtask

  typedef struct {
    logic [7:0] bm;
    int         stall;
    logic [7:0] e_dec;
    logic [7:0] e_mask;
    logic [2:0] e_best;
    logic [7:0] e_pmc0;  // cur_pm[0] seen on acs_p0_pmc at st=0
    logic [7:0] e_pmc2;  // cur_pm[1] seen on acs_p0_pmc at st=2
    logic       e_p1v0;  // cur_v[4] seen on acs_p1_valid at st=0
  } vec_t;

  vec_t vec [7];

  logic [7:0] g_pmc0;
  logic [7:0] g_pmc2;
  logic       g_p1v0;
  logic [7:0] g_dec;
  logic [7:0] g_mask;
  logic [2:0] g_best;
  int         seen;

  task automatic check_row(input vec_t v, input string tag);
    run_symbol(v.bm, v.stall, v.e_dec, v.e_mask, v.e_best,
               g_pmc0, g_pmc2, g_p1v0, g_dec, g_mask, g_best);
    check({tag, "_dec"}, {24'd0, g_dec}, {24'd0, v.e_dec});
    check({tag, "_mask"}, {24'd0, g_mask}, {24'd0, v.e_mask});
    check({tag, "_best"}, {29'd0, g_best}, {29'd0, v.e_best});
    check({tag, "_pmc0"}, {24'd0, g_pmc0}, {24'd0, v.e_pmc0});
    check({tag, "_pmc2"}, {24'd0, g_pmc2}, {24'd0, v.e_pmc2});
    check({tag, "_p1v0"}, {31'd0, g_p1v0}, {31'd0, v.e_p1v0});
  endtask

  initial begin
    total = 0;
    bad   = 0;
    // bm         stall dec    mask   best  pmc0   pmc2   p1v0
    vec[0] = '{8'h94, 0, 8'h00, 8'h03, 3'd0, 8'd0, 8'd0, 1'b0};
    vec[1] = '{8'h1B, 0, 8'h00, 8'h0F, 3'd1, 8'd0, 8'd2, 1'b0};
    vec[2] = '{8'h4E, 0, 8'h00, 8'hFF, 3'd2, 8'd3, 8'd0, 1'b0};
    vec[3] = '{8'h31, 0, 8'h01, 8'hFF, 3'd5, 8'd5, 8'd4, 1'b1};
    vec[4] = '{8'hFF, 0, 8'h3C, 8'hFF, 3'd2, 8'd2, 8'd5, 1'b1};
    vec[5] = '{8'h00, 5, 8'h00, 8'hFF, 3'd4, 8'd5, 8'd5, 1'b1};
    vec[6] = '{8'h00, 0, 8'hFF, 8'hFF, 3'd0, 8'd5, 8'd5, 1'b1};

    rst_n     = 1'b0;
    init      = 1'b0;
    sym_valid = 1'b0;
    dec_ready = 1'b1;
    bm_in     = 8'd0;

    // Reset state.
    @(negedge clk);
    #1;
    check("rst_sym_ready", {31'd0, sym_ready}, 32'd0);
    repeat (2) @(negedge clk);
    #1;
    check("rst_dec_valid", {31'd0, dec_valid}, 32'd0);
    check("rst_dec", {24'd0, dec}, 32'd0);
    check("rst_mask", {24'd0, dec_mask}, 32'd0);
    check("rst_best", {29'd0, best_state}, 32'd0);
    check("rst_acs_p0_valid", {31'd0, acs_p0_valid}, 32'd0);
    rst_n = 1'b1;
    #1;
    check("post_rst_sym_ready", {31'd0, sym_ready}, 32'd1);

    // Directed symbol sequence, including ties and a 5-cycle dec_ready stall.
    for (int i = 0; i < 7; i++) begin
      check_row(vec[i], $sformatf("row%0d", i));
    end

    // init together with sym_valid: init wins, symbol accepted the following cycle.
    @(negedge clk);
    init      = 1'b1;
    sym_valid = 1'b1;
    bm_in     = 8'h94;
    #1;
    check("init_sym_ready", {31'd0, sym_ready}, 32'd0);
    check_row(vec[0], "after_init");

    // Reset in the middle of RUN (st=4) abandons the symbol.
    @(negedge clk);
    bm_in     = 8'h1B;
    sym_valid = 1'b1;
    #1;
    check("midrst_accept", {31'd0, sym_ready}, 32'd1);
    repeat (5) begin
      @(negedge clk);
      sym_valid = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    check("midrst_sym_ready_low", {31'd0, sym_ready}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("midrst_dec_valid", {31'd0, dec_valid}, 32'd0);
    check("midrst_idle", {31'd0, sym_ready}, 32'd1);
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      #1;
      if (dec_valid) seen++;
    end
    check("midrst_no_word", seen, 32'd0);
    check_row(vec[0], "after_midrst");

    // Long run of equal metrics: normalisation on the 64th symbol.
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int n = 1; n <= 65; n++) begin
      run_symbol(8'hAA, 0, 8'h00, 8'hFF, 3'd0,
                 g_pmc0, g_pmc2, g_p1v0, g_dec, g_mask, g_best);
      if (n == 2) check("aa_sym2_pmc0", {24'd0, g_pmc0}, 32'd2);
      if (n == 64) begin
        check("aa_sym64_pmc0", {24'd0, g_pmc0}, 32'd126);
        check("aa_sym64_mask", {24'd0, g_mask}, 32'hFF);
        check("aa_sym64_dec", {24'd0, g_dec}, 32'h00);
        check("aa_sym64_best", {29'd0, g_best}, 32'd0);
      end
      if (n == 65) check("aa_sym65_pmc0", {24'd0, g_pmc0}, 32'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
